fnd_scan_reader: RTL and testbench

- Reader end of the multiplexed 7-segment (FND) display interface: samples an external device's active-low segment bus and digit-common lines, and recovers the hex value shown on each digit.
- Presents each recovered frame through a valid/ready handshake.
- Used by the board-level monitor to read displays driven by other boards or legacy controllers.

---
 rtl/fnd_scan_reader.sv | 165 ++++++++++++++++
 tb/tb_fnd_scan_reader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_reader.sv
// Reader for a multiplexed active-low 7-segment display bus.
// Captures each digit once its common and segments have settled, then hands out whole frames.
module fnd_scan_reader #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     com_in,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [4*DIGITS-1:0]   frame_hex,
    output logic [DIGITS-1:0]     frame_ok,
    output logic [DIGITS-1:0]     frame_err,
    output logic                  overrun
);

    // state   | meaning
    // COLLECT | capturing digits, captured mask not yet full
    // DELIVER | single cycle: publish the completed frame or drop it as overrun
    typedef enum logic {COLLECT, DELIVER} state_t;

    localparam int          SW         = DIGITS + 7;
    localparam logic [7:0]  STABLE_CNT = 8'(STABLE_CYC);

    state_t                state_q, state_d;
    logic [SW-1:0]         sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   slot_hex_q, slot_hex_d;
    logic [DIGITS-1:0]     slot_ok_q, slot_ok_d, slot_err_q, slot_err_d;
    logic [DIGITS-1:0]     captured_q, captured_d;
    logic                  frame_valid_q, frame_valid_d;
    logic [4*DIGITS-1:0]   frame_hex_q, frame_hex_d;
    logic [DIGITS-1:0]     frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;

    logic                  stable_evt;
    logic [DIGITS-1:0]     com_low, cap_set;
    logic [3:0]            n_low;
    logic [5:0]            dec;

    // Returns {err, ok, nibble}; B and D alias onto 8 and 0 on this bus.
    function automatic logic [5:0] decode(input logic [6:0] seg);
        case (seg)
            7'h01: decode = 6'b01_0000;
            7'h4F: decode = 6'b01_0001;
            7'h12: decode = 6'b01_0010;
            7'h06: decode = 6'b01_0011;
            7'h4C: decode = 6'b01_0100;
            7'h24: decode = 6'b01_0101;
            7'h20: decode = 6'b01_0110;
            7'h0D: decode = 6'b01_0111;
            7'h00: decode = 6'b01_1000;
            7'h04: decode = 6'b01_1001;
            7'h08: decode = 6'b01_1010;
            7'h31: decode = 6'b01_1100;
            7'h30: decode = 6'b01_1110;
            7'h38: decode = 6'b01_1111;
            7'h7F: decode = 6'b00_0000;
            default: decode = 6'b10_0000;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        sync1_d       = {com_in, seg_in};
        sync2_d       = sync1_q;
        prev_d        = sync2_q;
        cnt_d         = cnt_q;
        slot_hex_d    = slot_hex_q;
        slot_ok_d     = slot_ok_q;
        slot_err_d    = slot_err_q;
        captured_d    = captured_q;
        frame_valid_d = frame_valid_q;
        frame_hex_d   = frame_hex_q;
        frame_ok_d    = frame_ok_q;
        frame_err_d   = frame_err_q;
        overrun_d     = 1'b0;
        cap_set       = '0;
        n_low         = 4'd0;

        if (sync2_q != prev_q) cnt_d = 8'd1;
        else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        // Fires on the transition into STABLE_CNT only, so saturation at 255 cannot refire.
        stable_evt = (cnt_d == STABLE_CNT) && (cnt_q != STABLE_CNT);

        com_low = ~sync2_q[SW-1:7];
        dec     = decode(sync2_q[6:0]);
        for (int i = 0; i < DIGITS; i++)
            if (com_low[i]) n_low = n_low + 4'd1;

        for (int i = 0; i < DIGITS; i++) begin
            if (stable_evt && (n_low == 4'd1) && com_low[i]) begin
                slot_hex_d[4*i +: 4] = dec[3:0];
                slot_ok_d[i]         = dec[4];
                slot_err_d[i]        = dec[5];
                cap_set[i]           = 1'b1;
            end
        end

        if (frame_valid_q && frame_ready) frame_valid_d = 1'b0;

        case (state_q)
            COLLECT: begin
                captured_d = captured_q | cap_set;
                if (&captured_d) state_d = DELIVER;
            end
            DELIVER: begin
                captured_d = cap_set;
                state_d    = COLLECT;
                if (!frame_valid_q || frame_ready) begin
                    frame_valid_d = 1'b1;
                    frame_hex_d   = slot_hex_q;
                    frame_ok_d    = slot_ok_q;
                    frame_err_d   = slot_err_q;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= COLLECT;
            sync1_q       <= '0;
            sync2_q       <= '0;
            prev_q        <= '0;
            cnt_q         <= '0;
            slot_hex_q    <= '0;
            slot_ok_q     <= '0;
            slot_err_q    <= '0;
            captured_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_hex_q   <= '0;
            frame_ok_q    <= '0;
            frame_err_q   <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            slot_hex_q    <= slot_hex_d;
            slot_ok_q     <= slot_ok_d;
            slot_err_q    <= slot_err_d;
            captured_q    <= captured_d;
            frame_valid_q <= frame_valid_d;
            frame_hex_q   <= frame_hex_d;
            frame_ok_q    <= frame_ok_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_hex   = frame_hex_q;
    assign frame_ok    = frame_ok_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_fnd_scan_reader.sv
// Directed bench for fnd_scan_reader: scans patterns onto the bus and checks recovered frames.
module tb_fnd_scan_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = 7'h7F;
    logic [3:0]  com_in = 4'hF;
    logic        frame_valid;
    logic        frame_ready = 1'b1;
    logic [15:0] frame_hex;
    logic [3:0]  frame_ok;
    logic [3:0]  frame_err;
    logic        overrun;

    int          checks = 0;
    int          errors = 0;
    int          frames = 0;
    int          ovr_cycles = 0;
    logic [15:0] last_hex = '0;
    logic [3:0]  last_ok = '0;
    logic [3:0]  last_err = '0;
    int          f0, o0;

    fnd_scan_reader #(.DIGITS(4), .STABLE_CYC(4)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .com_in(com_in),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_hex(frame_hex), .frame_ok(frame_ok), .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Records every accepted frame and every cycle overrun is high.
    always @(negedge clk) begin
        if (frame_valid && frame_ready) begin
            frames++;
            last_hex = frame_hex;
            last_ok  = frame_ok;
            last_err = frame_err;
        end
        if (overrun) ovr_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] com, input logic [6:0] seg, input int n);
        @(posedge clk); #1;
        com_in = com;
        seg_in = seg;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic scan(input logic [6:0] s0, s1, s2, s3, input int n);
        drive(4'b1110, s0, n);
        drive(4'b1101, s1, n);
        drive(4'b1011, s2, n);
        drive(4'b0111, s3, n);
    endtask

    task automatic blank(input int n);
        drive(4'b1111, 7'h7F, n);
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk);
        check({tag, "_valid"},   32'(frame_valid), 32'h0);
        check({tag, "_hex"},     32'(frame_hex),   32'h0);
        check({tag, "_ok"},      32'(frame_ok),    32'h0);
        check({tag, "_err"},     32'(frame_err),   32'h0);
        check({tag, "_overrun"}, 32'(overrun),     32'h0);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [15:0] hex,
                               input logic [3:0] ok, input logic [3:0] err);
        check({tag, "_count"}, 32'(frames - base), 32'd1);
        check({tag, "_hex"},   32'(last_hex),      32'(hex));
        check({tag, "_ok"},    32'(last_ok),       32'(ok));
        check({tag, "_err"},   32'(last_err),      32'(err));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_outputs_zero("reset");

        // Plain 1,2,3,4 scan.
        f0 = frames;
        scan(7'h4F, 7'h12, 7'h06, 7'h4C, 10);
        blank(12);
        check_frame("scan1234", f0, 16'h4321, 4'hF, 4'h0);

        // Blank and undecodable digits.
        f0 = frames;
        scan(7'h4F, 7'h12, 7'h7F, 7'h55, 10);
        blank(12);
        check_frame("blank_bad", f0, 16'h0021, 4'b0011, 4'b1000);

        // Digits held one cycle too short never capture.
        f0 = frames;
        scan(7'h24, 7'h20, 7'h0D, 7'h00, 3);
        scan(7'h4F, 7'h12, 7'h06, 7'h4C, 3);
        blank(12);
        @(negedge clk);
        check("short_count", 32'(frames - f0), 32'd0);
        check("short_valid", 32'(frame_valid), 32'd0);
        f0 = frames;
        scan(7'h24, 7'h20, 7'h0D, 7'h00, 4);
        blank(12);
        check_frame("exact_hold", f0, 16'h8765, 4'hF, 4'h0);

        // Two commons active at once are ignored.
        f0 = frames;
        drive(4'b1100, 7'h4F, 20);
        scan(7'h04, 7'h08, 7'h31, 7'h30, 10);
        blank(12);
        check_frame("ghost", f0, 16'hECA9, 4'hF, 4'h0);

        // Back-pressure: first frame held, second dropped with a single overrun cycle.
        frame_ready = 1'b0;
        o0 = ovr_cycles;
        scan(7'h4F, 7'h12, 7'h06, 7'h4C, 10);
        blank(12);
        @(negedge clk);
        check("hold_valid", 32'(frame_valid), 32'd1);
        check("hold_hex1", 32'(frame_hex), 32'h4321);
        scan(7'h38, 7'h30, 7'h31, 7'h08, 10);
        blank(12);
        @(negedge clk);
        check("hold_hex2", 32'(frame_hex), 32'h4321);
        check("hold_ok", 32'(frame_ok), 32'hF);
        check("overrun_cycles", 32'(ovr_cycles - o0), 32'd1);
        @(posedge clk); #1 frame_ready = 1'b1;
        @(posedge clk); #1 frame_ready = 1'b0;
        @(negedge clk);
        check("ready_drop", 32'(frame_valid), 32'd0);
        frame_ready = 1'b1;

        // Reset mid-frame discards the partial capture.
        drive(4'b1110, 7'h4F, 10);
        drive(4'b1101, 7'h12, 10);
        drive(4'b1011, 7'h06, 10);
        blank(4);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_outputs_zero("midreset");
        f0 = frames;
        drive(4'b0111, 7'h4C, 10);
        blank(12);
        @(negedge clk);
        check("partial_count", 32'(frames - f0), 32'd0);
        check("partial_valid", 32'(frame_valid), 32'd0);
        f0 = frames;
        scan(7'h4F, 7'h12, 7'h06, 7'h4C, 10);
        blank(12);
        check_frame("rescan", f0, 16'h4321, 4'hF, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
